// File: rtl/rs1_read_arbiter_pkg.sv
// Shared definitions for the rs1 read arbiter: mux select codes, FSM
// state encoding and the round-robin rotation helper.
package rs1_read_arbiter_pkg;

   localparam logic [1:0] SEL_ADD    = 2'b00;
   localparam logic [1:0] SEL_MULT   = 2'b01;
   localparam logic [1:0] SEL_MULADD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   // Next requester index in rotation order 0 -> 1 -> 2 -> 0.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx >= SEL_MULADD) ? SEL_ADD : idx + 2'd1;
   endfunction

endpackage

// File: rtl/rs1_read_arbiter_if.sv
// Controller / register-file side bundle of the rs1 read arbiter.
interface rs1_read_arbiter_if #(parameter int DATA_W = 32);

   logic [2:0]        req;
   logic [2:0]        ack;
   logic [1:0]        rs1_sel;
   logic              rf_rd_en;
   logic [DATA_W-1:0] rf_rd_data;
   logic [DATA_W-1:0] rs1_data;
   logic              busy;

   // Environment side: controllers raise req, register file returns data.
   modport master (output req, rf_rd_data,
                   input  ack, rs1_sel, rf_rd_en, rs1_data, busy);

   // Arbiter side.
   modport slave  (input  req, rf_rd_data,
                   output ack, rs1_sel, rf_rd_en, rs1_data, busy);

endinterface

// File: rtl/rs1_read_arbiter_rr_arb3.sv
// Combinational 3-way round-robin pick. Priority starts one past the
// last granted index and wraps 2 -> 0.
module rr_arb3
   import rs1_read_arbiter_pkg::*;
(
   input  logic [2:0] i_req,
   input  logic [1:0] i_last_grant,
   output logic [1:0] o_winner,
   output logic       o_any_req
);

   logic [1:0] w_p0, w_p1, w_p2;

   // Priority order derived from the previous winner.
   always_comb begin
      w_p0 = rr_next(i_last_grant);
      w_p1 = rr_next(w_p0);
      w_p2 = rr_next(w_p1);
   end

   // Highest-priority active request wins; winner is don't-care when idle.
   always_comb begin
      o_any_req = |i_req;
      o_winner  = w_p2;
      if (i_req[w_p0])      o_winner = w_p0;
      else if (i_req[w_p1]) o_winner = w_p1;
   end

endmodule

// File: rtl/rs1_read_arbiter.sv
// rs1 register-read sequencer: grants one controller at a time, strobes
// the register-file read, captures the data and acknowledges the winner.
module rs1_read_arbiter
   import rs1_read_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int N_REQ  = 3
)(
   input  logic               clk,
   input  logic               rst_n,
   rs1_read_arbiter_if.slave  bus
);

   state_e            r_state, w_state_nxt;
   logic [1:0]        r_grant_idx, r_last_grant, w_winner;
   logic              w_any_req;
   logic [DATA_W-1:0] r_rs1_data;
   logic [N_REQ-1:0]  w_ack;

   rr_arb3 u_arb (
      .i_req        (bus.req),
      .i_last_grant (r_last_grant),
      .o_winner     (w_winner),
      .o_any_req    (w_any_req)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and the ack decode from registered state.
   always_comb begin
      w_state_nxt = r_state;
      w_ack       = '0;
      unique case (r_state)
         ST_IDLE: if (w_any_req) w_state_nxt = ST_READ;
         ST_READ: w_state_nxt = ST_WAIT;
         ST_WAIT: w_state_nxt = ST_RESP;
         ST_RESP: begin
            w_state_nxt        = ST_IDLE;
            w_ack[r_grant_idx] = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Grant latch (doubles as rs1_sel, so it holds through IDLE), data
   // capture in WAIT, and rotation pointer update on completion only so a
   // reset-dropped transaction does not advance priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_grant_idx  <= SEL_ADD;
         r_last_grant <= SEL_MULADD;
         r_rs1_data   <= '0;
      end else begin
         if (r_state == ST_IDLE && w_any_req) r_grant_idx  <= w_winner;
         if (r_state == ST_WAIT)              r_rs1_data   <= bus.rf_rd_data;
         if (r_state == ST_RESP)              r_last_grant <= r_grant_idx;
      end
   end

   assign bus.ack      = w_ack;
   assign bus.rs1_sel  = r_grant_idx;
   assign bus.rf_rd_en = (r_state == ST_READ);
   assign bus.busy     = (r_state != ST_IDLE);
   assign bus.rs1_data = r_rs1_data;

endmodule
